multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Sequencing controller for the multi-cycle RV32I datapath (lw, sw, R-type, I-type ALU, beq, jal).
//  Moore FSM; each state drives the datapath mux selects and write enables.
//  Stalls on a ready handshake for shared instruction/data memory.
//  ALUOp output feeds the existing ALU decoder; ImmSrc drives the immediate extender; also counts retired instructions.
// PARAMETERS
//  INSTRET_W  32  width of retired-instruction counter
// PORTS
//  clk        in   1          clock; all state updates on rising edge
//  rst        in   1          synchronous, active-high reset
//  Op         in   7          opcode field of the instruction register
//  Zero       in   1          ALU zero flag
//  mem_ready  in   1          memory has completed the current request this cycle
//  mem_req    out  1          memory access request
//  AdrSrc     out  1          0: address = PC, 1: address = ALUOut
//  IRWrite    out  1          load instruction register and OldPC
//  PCWrite    out  1          PC register enable
//  RegWrite   out  1          register file write enable
//  MemWrite   out  1          memory write strobe
//  ResultSrc  out  2          00 ALUOut, 01 Data, 10 ALUResult
//  ALUSrcA    out  2          00 PC, 01 OldPC, 10 rs1
//  ALUSrcB    out  2          00 rs2, 01 ImmExt, 10 constant 4
//  ALUOp      out  2          00 add, 01 sub, 10 funct-decoded
//  ImmSrc     out  2          combinational from Op: I/lw 00, sw 01, beq 10, jal 11, other 00
//  instret    out  INSTRET_W  retired-instruction count
//  illegal    out  1          illegal-opcode trap flag
// BEHAVIOUR
//  Clock and reset: clk, rst (synchronous, active-high). While rst=1:
//   - state <= FETCH; instret <= 0; illegal <= 0.
//   - IRWrite, PCWrite, RegWrite, MemWrite and mem_req are forced to 0.
//  Output defaults: every select/enable not listed for a state is 0. PCWrite = PCUpdate | (Branch & Zero), where PCUpdate and Branch are internal.
//  States (unlisted selects = 0):
//   FETCH    mem_req=1, ALUSrcB=10, ResultSrc=10. IRWrite=PCUpdate=mem_ready. ready -> DECODE, else hold.
//   DECODE   ALUSrcA=01, ALUSrcB=01 (branch target precompute). Next state by Op:
//            0000011, 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI;
//            1100011 -> BEQ; 1101111 -> JAL; other -> see CONFIGURATION.
//   MEMADR   ALUSrcA=10, ALUSrcB=01. Op[5]=0 -> MEMREAD, Op[5]=1 -> MEMWRITE.
//   MEMREAD  mem_req=1, AdrSrc=1. ready -> MEMWB, else hold.
//   MEMWB    ResultSrc=01, RegWrite=1 -> FETCH.
//   MEMWRITE mem_req=1, AdrSrc=1, MemWrite=mem_ready. ready -> FETCH, else hold.
//   EXECUTER ALUSrcA=10, ALUOp=10 -> ALUWB.
//   EXECUTEI ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
//   ALUWB    RegWrite=1 -> FETCH.
//   JAL      ALUSrcA=01, ALUSrcB=10, PCUpdate=1 -> ALUWB.
//   BEQ      ALUSrcA=10, ALUOp=01, Branch=1 -> FETCH.
//  Latency with mem_ready held high: lw 5, sw 4, R/I 4, jal 4, beq 3 cycles.
//  Every wait cycle adds one cycle; outputs stay stable while holding.
//  instret += 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ; wraps modulo 2^INSTRET_W.
//  mem_ready is ignored in states without mem_req.
//  rst in any state aborts the instruction; no partial write is issued in the rst cycle.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined:
//   - unknown Op in DECODE -> TRAP; illegal=1; all enables 0.
//   - TRAP is held until rst.
//  ILLEGAL_TRAP_EN undefined:
//   - unknown Op in DECODE -> FETCH (executes as a NOP, not counted in instret).
//   - illegal is tied to 0; no TRAP state exists.
// TESTING
//  Reset: rst=1 for 2 cycles in EXECUTER -> state FETCH, instret=0, no enables during rst.
//  lw, mem_ready=1: states F,D,MA,MR,MWB. RegWrite=1 in cycle 5 only. instret=1.
//  sw with mem_ready low 3 cycles in MEMWRITE: MemWrite=1 for exactly 1 cycle, total 7 cycles.
//  beq, Zero=1: PCWrite=1 in BEQ cycle; with Zero=0: PCWrite=0; both retire in 3 cycles.
//  jal: PCWrite=1 in JAL state; RegWrite=1 in ALUWB with ResultSrc=00.
//  Op=0000000: with macro, illegal=1 and held in TRAP; without, back to FETCH, instret unchanged.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Moore sequencing controller for the multi-cycle RV32I datapath (lw, sw, R/I ALU, beq, jal).
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP with illegal=1 until rst.
module multicycle_control_fsm #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           Op,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic [1:0]           ImmSrc,
  output logic [INSTRET_W-1:0] instret,
  output logic                 illegal
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, JAL, BEQ
`ifdef ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [INSTRET_W-1:0]   instret_r;
  logic                   illegal_r;
  logic                   retire_s;
  logic                   pcupdate_s;
  logic                   branch_s;
  logic                   mem_req_s;
  logic                   irwrite_s;
  logic                   regwrite_s;
  logic                   memwrite_s;

  // State register, retired-instruction counter and trap flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= FETCH;
      instret_r <= {INSTRET_W{1'b0}};
      illegal_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (retire_s) begin
        instret_r <= instret_r + {{(INSTRET_W-1){1'b0}}, 1'b1};
      end else begin
        instret_r <= instret_r;
      end
`ifdef ILLEGAL_TRAP_EN
      illegal_r <= (state_next_s == TRAP);
`else
      illegal_r <= 1'b0;
`endif
    end
  end

  // Next-state logic and per-state datapath controls
  always_comb begin
    state_next_s = state_r;
    mem_req_s    = 1'b0;
    AdrSrc       = 1'b0;
    irwrite_s    = 1'b0;
    pcupdate_s   = 1'b0;
    branch_s     = 1'b0;
    regwrite_s   = 1'b0;
    memwrite_s   = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    case (state_r)
      FETCH: begin
        mem_req_s  = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        irwrite_s  = mem_ready;
        pcupdate_s = mem_ready;
        if (mem_ready) begin
          state_next_s = DECODE;
        end else begin
          state_next_s = FETCH;
        end
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (Op)
          OP_LW, OP_SW: state_next_s = MEMADR;
          OP_R:         state_next_s = EXECUTER;
          OP_I:         state_next_s = EXECUTEI;
          OP_BEQ:       state_next_s = BEQ;
          OP_JAL:       state_next_s = JAL;
`ifdef ILLEGAL_TRAP_EN
          default:      state_next_s = TRAP;
`else
          default:      state_next_s = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (Op[5]) begin
          state_next_s = MEMWRITE;
        end else begin
          state_next_s = MEMREAD;
        end
      end
      MEMREAD: begin
        mem_req_s = 1'b1;
        AdrSrc    = 1'b1;
        if (mem_ready) begin
          state_next_s = MEMWB;
        end else begin
          state_next_s = MEMREAD;
        end
      end
      MEMWB: begin
        ResultSrc    = 2'b01;
        regwrite_s   = 1'b1;
        state_next_s = FETCH;
      end
      MEMWRITE: begin
        mem_req_s  = 1'b1;
        AdrSrc     = 1'b1;
        memwrite_s = mem_ready;
        if (mem_ready) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = MEMWRITE;
        end
      end
      EXECUTER: begin
        ALUSrcA      = 2'b10;
        ALUOp        = 2'b10;
        state_next_s = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b01;
        ALUOp        = 2'b10;
        state_next_s = ALUWB;
      end
      ALUWB: begin
        regwrite_s   = 1'b1;
        state_next_s = FETCH;
      end
      JAL: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        pcupdate_s   = 1'b1;
        state_next_s = ALUWB;
      end
      BEQ: begin
        ALUSrcA      = 2'b10;
        ALUOp        = 2'b01;
        branch_s     = 1'b1;
        state_next_s = FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: begin
        state_next_s = TRAP;
      end
`endif
      default: begin
        state_next_s = FETCH;
      end
    endcase
  end

  // Immediate format select decoded straight from the opcode
  always_comb begin
    ImmSrc = 2'b00;
    case (Op)
      OP_LW, OP_I: ImmSrc = 2'b00;
      OP_SW:       ImmSrc = 2'b01;
      OP_BEQ:      ImmSrc = 2'b10;
      OP_JAL:      ImmSrc = 2'b11;
      default:     ImmSrc = 2'b00;
    endcase
  end

  // Retirement happens on the edge that returns to FETCH from a final state
  assign retire_s = (state_next_s == FETCH) &&
                    ((state_r == MEMWB) || (state_r == MEMWRITE) ||
                     (state_r == ALUWB) || (state_r == BEQ));

  // Enables are suppressed in the reset cycle so no partial write escapes
  assign mem_req  = mem_req_s  & ~rst;
  assign IRWrite  = irwrite_s  & ~rst;
  assign PCWrite  = (pcupdate_s | (branch_s & Zero)) & ~rst;
  assign RegWrite = regwrite_s & ~rst;
  assign MemWrite = memwrite_s & ~rst;
  assign instret  = instret_r;
  assign illegal  = illegal_r;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: an instruction-level model queues expected
// per-cycle controls; a negedge monitor pops and compares them against the DUT.
module tb_multicycle_control_fsm;
  localparam int W = 32;

  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5;
  localparam int P_ER = 6, P_EI = 7, P_AWB = 8, P_JAL = 9, P_BEQ = 10, P_TRAP = 11;

  logic         clk = 1'b0;
  logic         rst;
  logic [6:0]   Op;
  logic         Zero;
  logic         mem_ready;
  logic         mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite;
  logic [1:0]   ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic [W-1:0] instret;
  logic         illegal;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.INSTRET_W(W)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
    .instret(instret), .illegal(illegal)
  );

  typedef struct {
    logic [16:0]  ctrl;
    logic [W-1:0] ir;
    int           ph;
  } exp_t;

  exp_t         q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  logic [W-1:0] m_instret;
  int           hold_phase = -1;
  int           hold_cnt = 0;
  bit           rand_ready = 1'b1;
  int           illegal_toggle = 0;

  function automatic logic [6:0] op_of(input int kind);
    case (kind)
      0: return 7'b0000011;
      1: return 7'b0100011;
      2: return 7'b0110011;
      3: return 7'b0010011;
      4: return 7'b1100011;
      5: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [16:0] ctrl_of(input int ph, input logic rdy, input logic z,
                                          input logic r, input logic [6:0] op);
    logic mreq, adr, irw, pcw, rw, mw, ill;
    logic [1:0] rs, sa, sb, aop, imm;
    {mreq, adr, irw, pcw, rw, mw, ill} = 7'b0000000;
    {rs, sa, sb, aop} = 8'h00;
    case (op)
      7'b0100011: imm = 2'b01;
      7'b1100011: imm = 2'b10;
      7'b1101111: imm = 2'b11;
      default:    imm = 2'b00;
    endcase
    case (ph)
      P_F:    begin mreq = 1'b1; sb = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
      P_D:    begin sa = 2'b01; sb = 2'b01; end
      P_MA:   begin sa = 2'b10; sb = 2'b01; end
      P_MR:   begin mreq = 1'b1; adr = 1'b1; end
      P_MWB:  begin rs = 2'b01; rw = 1'b1; end
      P_MW:   begin mreq = 1'b1; adr = 1'b1; mw = rdy; end
      P_ER:   begin sa = 2'b10; aop = 2'b10; end
      P_EI:   begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      P_AWB:  begin rw = 1'b1; end
      P_JAL:  begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
      P_BEQ:  begin sa = 2'b10; aop = 2'b01; pcw = z; end
      default: begin ill = 1'b1; end
    endcase
    if (r) begin
      {mreq, irw, pcw, rw, mw} = 5'b00000;
    end
    return {mreq, adr, irw, pcw, rw, mw, rs, sa, sb, aop, imm, ill};
  endfunction

  function automatic bit is_mem(input int ph);
    return (ph == P_F) || (ph == P_MR) || (ph == P_MW);
  endfunction

  // Monitor: compare every queued expectation against the DUT on the falling edge
  exp_t        mon_e;
  logic [16:0] mon_act;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e   = q.pop_front();
      mon_act = {mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite,
                 ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal};
      n_checks++;
      if (mon_act !== mon_e.ctrl) begin
        n_fail++;
        $display("FAIL ctrl phase=%0d t=%0t: got %h expected %h", mon_e.ph, $time, mon_act, mon_e.ctrl);
      end
      n_checks++;
      if (instret !== mon_e.ir) begin
        n_fail++;
        $display("FAIL instret phase=%0d t=%0t: got %0d expected %0d", mon_e.ph, $time, instret, mon_e.ir);
      end
    end
  end

  task automatic step(input int ph, input logic r, input bit force_rdy, output logic rdy);
    logic z;
    z = 1'($urandom_range(0, 1));
    if (ph == hold_phase && hold_cnt > 0) begin
      rdy = 1'b0;
      hold_cnt--;
    end else if (rand_ready && !force_rdy) begin
      rdy = ($urandom_range(0, 3) != 0);
    end else begin
      rdy = 1'b1;
    end
    mem_ready = rdy;
    Zero      = z;
    rst       = r;
    q.push_back('{ctrl_of(ph, rdy, z, r, Op), m_instret, ph});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int ph, input int n);
    logic rdy;
    step(ph, 1'b1, 1'b0, rdy);
    m_instret = '0;
    for (int k = 1; k < n; k++) step(P_F, 1'b1, 1'b0, rdy);
    rst = 1'b0;
  endtask

  task automatic run_instr(input int kind, input int abort_idx);
    int   ph[$];
    int   waits;
    logic rdy;
    case (kind)
      0: ph = '{P_F, P_D, P_MA, P_MR, P_MWB};
      1: ph = '{P_F, P_D, P_MA, P_MW};
      2: ph = '{P_F, P_D, P_ER, P_AWB};
      3: ph = '{P_F, P_D, P_EI, P_AWB};
      4: ph = '{P_F, P_D, P_BEQ};
      5: ph = '{P_F, P_D, P_JAL, P_AWB};
`ifdef ILLEGAL_TRAP_EN
      default: ph = '{P_F, P_D, P_TRAP};
`else
      default: ph = '{P_F, P_D};
`endif
    endcase
    Op = op_of(kind);
    if (kind == 6) begin
      illegal_toggle++;
      if (illegal_toggle % 2 == 0) Op = 7'b1110011;
    end
    for (int i = 0; i < ph.size(); i++) begin
      if (i == abort_idx) begin
        do_reset(ph[i], 2);
        return;
      end
      if (ph[i] == P_TRAP) begin
        repeat (3) step(P_TRAP, 1'b0, 1'b0, rdy);
        do_reset(P_TRAP, 1);
        return;
      end
      waits = 0;
      forever begin
        step(ph[i], 1'b0, waits >= 6, rdy);
        if (!is_mem(ph[i]) || rdy) break;
        waits++;
      end
      if (ph[i] == P_MWB || ph[i] == P_MW || ph[i] == P_AWB || ph[i] == P_BEQ)
        m_instret = m_instret + 1;
    end
  endtask

  initial begin
    logic rdy;
    rst = 1'b1; Op = 7'b0000011; Zero = 1'b0; mem_ready = 1'b0; m_instret = '0;
    repeat (2) @(posedge clk);
    #1;
    step(P_F, 1'b1, 1'b1, rdy);
    rand_ready = 1'b0;
    run_instr(2, 2);
    run_instr(0, -1);
    hold_phase = P_MW; hold_cnt = 3;
    run_instr(1, -1);
    hold_phase = -1;
    run_instr(4, -1);
    run_instr(4, -1);
    run_instr(5, -1);
    run_instr(3, -1);
    run_instr(6, -1);
    run_instr(0, -1);
    run_instr(1, 3);
    run_instr(0, 3);
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      run_instr($urandom_range(0, 6),
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 2)) : -1);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
